// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard/bypass controller: tracks in-flight destinations, emits bypass selects and load-use stalls.
// Optional performance counters enabled by defining HAZ_PERF_CNT_EN.
module id_hazard_ctrl #(
  parameter int unsigned RF_AW = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] p0_addr,
  input  logic [RF_AW-1:0] p1_addr,
  input  logic             re0,
  input  logic             re1,
  input  logic [RF_AW-1:0] dst_addr_ID,
  input  logic             rf_we_ID,
  input  logic             ld_ID,
  input  logic             flush,
  input  logic             stall_ext,
  output logic             byp0_EX,
  output logic             byp0_DM,
  output logic             byp1_EX,
  output logic             byp1_DM,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             stall_DM_WB,
  output logic             bubble_ID_EX,
  output logic [CNT_W-1:0] ld_use_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [RF_AW-1:0] dst_ID_EX, dst_EX_DM;
  logic             we_ID_EX, ld_ID_EX, we_EX_DM;
  logic             m_ex0, m_ex1, m_dm0, m_dm1, lu;

  // Source/destination match terms; R0 is hardwired and never forwarded
  always_comb begin
    m_ex0 = re0 & we_ID_EX & (dst_ID_EX == p0_addr) & (p0_addr != '0);
    m_ex1 = re1 & we_ID_EX & (dst_ID_EX == p1_addr) & (p1_addr != '0);
    m_dm0 = re0 & we_EX_DM & (dst_EX_DM == p0_addr) & (p0_addr != '0);
    m_dm1 = re1 & we_EX_DM & (dst_EX_DM == p1_addr) & (p1_addr != '0);
    lu    = ld_ID_EX & (m_ex0 | m_ex1);
  end

  // External freeze dominates; flush kills the consumer so it overrides the load-use hold
  always_comb begin
    stall_PC     = stall_ext | (lu & ~flush);
    stall_IF_ID  = stall_ext | (lu & ~flush);
    stall_ID_EX  = stall_ext;
    stall_EX_DM  = stall_ext;
    stall_DM_WB  = stall_ext;
    bubble_ID_EX = ~stall_ext & (flush | lu);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_ID_EX <= '0;
      we_ID_EX  <= 1'b0;
      ld_ID_EX  <= 1'b0;
      dst_EX_DM <= '0;
      we_EX_DM  <= 1'b0;
      byp0_EX   <= 1'b0;
      byp0_DM   <= 1'b0;
      byp1_EX   <= 1'b0;
      byp1_DM   <= 1'b0;
    end else if (!stall_ext) begin
      dst_ID_EX <= dst_addr_ID;
      we_ID_EX  <= rf_we_ID & ~bubble_ID_EX;
      ld_ID_EX  <= ld_ID & ~bubble_ID_EX;
      dst_EX_DM <= dst_ID_EX;
      we_EX_DM  <= we_ID_EX;
      byp0_EX   <= m_ex0 & ~bubble_ID_EX;
      byp0_DM   <= m_dm0 & ~m_ex0 & ~bubble_ID_EX;
      byp1_EX   <= m_ex1 & ~bubble_ID_EX;
      byp1_DM   <= m_dm1 & ~m_ex1 & ~bubble_ID_EX;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_use_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (lu && !stall_ext && !flush && (ld_use_cnt != '1))
        ld_use_cnt <= ld_use_cnt + CNT_W'(1);
      if (stall_ext && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign ld_use_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus random traffic against an instruction-record model.
module tb_id_hazard_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr, p1_addr, dst_addr_ID;
  logic          re0, re1, rf_we_ID, ld_ID, flush, stall_ext;
  logic          byp0_EX, byp0_DM, byp1_EX, byp1_DM;
  logic          stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX;
  logic [CW-1:0] ld_use_cnt, stall_cnt;

  id_hazard_ctrl #(.RF_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .dst_addr_ID(dst_addr_ID), .rf_we_ID(rf_we_ID), .ld_ID(ld_ID),
    .flush(flush), .stall_ext(stall_ext),
    .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX), .byp1_DM(byp1_DM),
    .stall_PC(stall_PC), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .stall_DM_WB(stall_DM_WB), .bubble_ID_EX(bubble_ID_EX),
    .ld_use_cnt(ld_use_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: records of the instructions sitting in EX (slot 0) and DM (slot 1)
  typedef struct { logic [AW-1:0] dst; bit we; bit ld; } instr_t;
  instr_t        pipe [2];
  bit            e_byp [4];  // 0:byp0_EX 1:byp0_DM 2:byp1_EX 3:byp1_DM
  int unsigned   e_lu_cnt, e_st_cnt;
  int            passed = 0;
  int            total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit hit(input logic [AW-1:0] a, input bit re, input instr_t e);
    return re && e.we && (e.dst == a) && (a != 0);
  endfunction

  function automatic bit load_use();
    return pipe[0].ld && (hit(p0_addr, re0, pipe[0]) || hit(p1_addr, re1, pipe[0]));
  endfunction

  function automatic bit exp_bubble();
    return !stall_ext && (flush || load_use());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) pipe[i] = '{dst: '0, we: 0, ld: 0};
    for (int i = 0; i < 4; i++) e_byp[i] = 0;
    e_lu_cnt = 0;
    e_st_cnt = 0;
  endtask

  task automatic drive(input logic [AW-1:0] dst, input bit we, input bit ld,
                       input logic [AW-1:0] a0, input bit r0, input logic [AW-1:0] a1, input bit r1,
                       input bit fl, input bit sx);
    dst_addr_ID = dst; rf_we_ID = we; ld_ID = ld;
    p0_addr = a0; re0 = r0; p1_addr = a1; re1 = r1;
    flush = fl; stall_ext = sx;
    #1;
  endtask

  task automatic check_model();
    bit lu;
    lu = load_use();
    check("stall_PC", stall_PC, stall_ext || (lu && !flush));
    check("stall_IF_ID", stall_IF_ID, stall_ext || (lu && !flush));
    check("stall_ID_EX", stall_ID_EX, stall_ext);
    check("stall_EX_DM", stall_EX_DM, stall_ext);
    check("stall_DM_WB", stall_DM_WB, stall_ext);
    check("bubble_ID_EX", bubble_ID_EX, exp_bubble());
    check("byp0_EX", byp0_EX, e_byp[0]);
    check("byp0_DM", byp0_DM, e_byp[1]);
    check("byp1_EX", byp1_EX, e_byp[2]);
    check("byp1_DM", byp1_DM, e_byp[3]);
`ifdef HAZ_PERF_CNT_EN
    check("ld_use_cnt", ld_use_cnt, e_lu_cnt);
    check("stall_cnt", stall_cnt, e_st_cnt);
`else
    check("ld_use_cnt", ld_use_cnt, 0);
    check("stall_cnt", stall_cnt, 0);
`endif
  endtask

  // Advance the model across one clock edge, then settle at the falling edge
  task automatic tick();
    bit b, lu, ex0, ex1, dm0, dm1;
    b   = exp_bubble();
    lu  = load_use();
    ex0 = hit(p0_addr, re0, pipe[0]); ex1 = hit(p1_addr, re1, pipe[0]);
    dm0 = hit(p0_addr, re0, pipe[1]); dm1 = hit(p1_addr, re1, pipe[1]);
    @(posedge clk);
    if (stall_ext) begin
      if (e_st_cnt < 32'hFFFF) e_st_cnt++;
    end else begin
      if (lu && !flush && e_lu_cnt < 32'hFFFF) e_lu_cnt++;
      e_byp[0] = ex0 && !b;
      e_byp[1] = dm0 && !ex0 && !b;
      e_byp[2] = ex1 && !b;
      e_byp[3] = dm1 && !ex1 && !b;
      pipe[1] = pipe[0];
      pipe[0] = '{dst: dst_addr_ID, we: rf_we_ID && !b, ld: ld_ID && !b};
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [AW-1:0] dst, input bit we, input bit ld,
                      input logic [AW-1:0] a0, input bit r0, input logic [AW-1:0] a1, input bit r1,
                      input bit fl, input bit sx);
    drive(dst, we, ld, a0, r0, a1, r1, fl, sx);
    check_model();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_model();
    check("reset_byp0_EX", byp0_EX, 0);
    check("reset_stall_PC", stall_PC, 0);

    // EX bypass: ADD R3 then ADD R4,R3,R5
    step(3, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(4, 1, 0, 3, 1, 5, 1, 0, 0);
    check("ex_nostall", stall_PC, 0);
    check_model(); tick();
    check("ex_byp0_EX", byp0_EX, 1);
    check("ex_byp0_DM", byp0_DM, 0);

    // DM bypass: ADD R3, NOP, SUB R6,R5,R3
    step(3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(6, 1, 0, 5, 1, 3, 1, 0, 0);
    check("dm_byp1_DM", byp1_DM, 1);
    check("dm_byp1_EX", byp1_EX, 0);

    // Load-use: LW R2 then ADD R7,R2,R2 -> one bubble then DM bypass on both ports
    do_reset();
    step(2, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(7, 1, 0, 2, 1, 2, 1, 0, 0);
    check("lu_stall_PC", stall_PC, 1);
    check("lu_stall_IF_ID", stall_IF_ID, 1);
    check("lu_bubble", bubble_ID_EX, 1);
    check("lu_stall_ID_EX", stall_ID_EX, 0);
    check_model(); tick();
    drive(7, 1, 0, 2, 1, 2, 1, 0, 0);
    check("lu_release", stall_PC, 0);
    check_model(); tick();
    check("lu_byp0_DM", byp0_DM, 1);
    check("lu_byp1_DM", byp1_DM, 1);
    check("lu_byp0_EX", byp0_EX, 0);
    check("lu_byp1_EX", byp1_EX, 0);
`ifdef HAZ_PERF_CNT_EN
    check("lu_cnt_one", ld_use_cnt, 1);
`endif

    // R0 never bypasses; EX wins over DM for the same register
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(5, 0, 0, 0, 1, 0, 1, 0, 0);
    check("r0_byp0", {byp0_EX, byp0_DM, byp1_EX, byp1_DM}, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(8, 1, 0, 1, 1, 0, 0, 0, 0);
    check("prio_byp0_EX", byp0_EX, 1);
    check("prio_byp0_DM", byp0_DM, 0);

    // Flush in the same cycle as a load-use
    step(2, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(7, 1, 0, 2, 1, 2, 1, 1, 0);
    check("fl_stall_PC", stall_PC, 0);
    check("fl_bubble", bubble_ID_EX, 1);
    check_model(); tick();
    check("fl_byp", {byp0_EX, byp0_DM, byp1_EX, byp1_DM}, 0);

    // External freeze for three cycles between producer and consumer
    do_reset();
    step(5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(9, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(6, 1, 0, 9, 1, 5, 1, 1, 1);
    check("sx_frozen", {byp0_EX, byp0_DM, byp1_EX, byp1_DM}, 0);
`ifdef HAZ_PERF_CNT_EN
    check("sx_cnt_three", stall_cnt, 3);
`endif
    step(6, 1, 0, 9, 1, 5, 1, 0, 0);
    check("sx_resume_byp0_EX", byp0_EX, 1);
    check("sx_resume_byp1_DM", byp1_DM, 1);

    // Asynchronous reset while a load-use stall is active
    step(2, 1, 1, 0, 0, 0, 0, 0, 0);
    drive(7, 1, 0, 2, 1, 2, 1, 0, 0);
    check("ar_pre_stall", stall_PC, 1);
    #1 rst = 1'b1;
    #1;
    check("ar_stall_PC", stall_PC, 0);
    check("ar_bubble", bubble_ID_EX, 0);
    check("ar_byp", {byp0_EX, byp0_DM, byp1_EX, byp1_DM}, 0);
    check("ar_cnt", {ld_use_cnt, stall_cnt}, 0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Random traffic over a small register window to provoke frequent matches
    for (int n = 0; n < 400; n++) begin
      step(AW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 3)), 1'($urandom), AW'($urandom_range(0, 3)), 1'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
